// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with debounced per-channel duty buttons.
// Shadowed duty loads at each channel's period boundary.
module pwm_multi_channel #(
  parameter int CHANNELS      = 4,
  parameter int PERIOD        = 10,
  parameter int DUTY_INIT     = 5,
  parameter int STEP          = 1,
  parameter int DEBOUNCE_DIV  = 2,
  parameter int PHASE_STAGGER = 0,
  parameter int DW            = $clog2(PERIOD + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [CHANNELS-1:0]    inc_btn,
  input  logic [CHANNELS-1:0]    dec_btn,
  output logic [CHANNELS-1:0]    pwm_out,
  output logic [CHANNELS*DW-1:0] duty_o,
  output logic                   period_start
);

  localparam int DVW =
    (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int OFF = PERIOD / CHANNELS;
  localparam logic [DW-1:0] P_LAST = DW'(PERIOD - 1);
  localparam logic [DW-1:0] P_FULL = DW'(PERIOD);
  localparam logic [DW-1:0] D_INIT = DW'(DUTY_INIT);

  logic [DVW-1:0]      div;
  logic                tick;
  logic [DW-1:0]       cnt;
  logic [CHANNELS-1:0] inc_s1, inc_s2;
  logic [CHANNELS-1:0] dec_s1, dec_s2;
  logic [CHANNELS-1:0] inc_p, dec_p;
  logic [CHANNELS-1:0] pwm_nxt;

  assign tick  = (div == DVW'(DEBOUNCE_DIV - 1));
  assign inc_p = inc_s1 & ~inc_s2 & {CHANNELS{tick}};
  assign dec_p = dec_s1 & ~dec_s2 & {CHANNELS{tick}};

  // Debounce sample-tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Button samplers, advanced only on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_s1 <= '0;
      inc_s2 <= '0;
      dec_s1 <= '0;
      dec_s2 <= '0;
    end else if (tick) begin
      inc_s1 <= inc_btn;
      inc_s2 <= inc_s1;
      dec_s1 <= dec_btn;
      dec_s2 <= dec_s1;
    end
  end

  // Shared period counter, parked at 0 while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (!en)            cnt <= '0;
    else if (cnt == P_LAST)  cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam int SH = (PHASE_STAGGER != 0) ? g * OFF : 0;

    logic [DW:0]   sum;
    logic [DW-1:0] phase;
    logic [DW-1:0] tgt;
    logic [DW-1:0] act;

    assign sum   = {1'b0, cnt} + (DW+1)'(SH);
    assign phase = (sum >= (DW+1)'(PERIOD))
                 ? DW'(sum - (DW+1)'(PERIOD))
                 : sum[DW-1:0];

    // Saturating duty target; simultaneous inc/dec cancel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tgt <= D_INIT;
      end else begin
        unique case (1'b1)
          inc_p[g] & ~dec_p[g]:
            if (32'(tgt) + STEP > PERIOD) tgt <= P_FULL;
            else tgt <= DW'(32'(tgt) + STEP);
          dec_p[g] & ~inc_p[g]:
            if (32'(tgt) < STEP) tgt <= '0;
            else tgt <= DW'(32'(tgt) - STEP);
          default: ;
        endcase
      end
    end

    // Shadow duty: loads on the last phase, tracks while idle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               act <= D_INIT;
      else if (!en)             act <= tgt;
      else if (phase == P_LAST) act <= tgt;
    end

    assign pwm_nxt[g]            = en & (phase < act);
    assign duty_o[g*DW +: DW]    = act;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= pwm_nxt;
      period_start <= en & (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel.
// Aligned instance plus a phase-staggered instance.
module tb_pwm_multi_channel;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  inc_btn, dec_btn;
  logic [3:0]  pwm_out;
  logic [15:0] duty_o;
  logic        period_start;
  logic [3:0]  zb_inc, zb_dec;
  logic [3:0]  pwm_s;
  logic [15:0] duty_s;
  logic        ps_s;

  int checks = 0;
  int errors = 0;

  logic [9:0] w  [4];
  logic [9:0] ws [4];
  logic [9:0] ps;

  pwm_multi_channel #(
    .CHANNELS(4), .PERIOD(10), .DUTY_INIT(5),
    .STEP(1), .DEBOUNCE_DIV(2), .PHASE_STAGGER(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .inc_btn(inc_btn), .dec_btn(dec_btn),
    .pwm_out(pwm_out), .duty_o(duty_o),
    .period_start(period_start)
  );

  pwm_multi_channel #(
    .CHANNELS(4), .PERIOD(10), .DUTY_INIT(5),
    .STEP(1), .DEBOUNCE_DIV(2), .PHASE_STAGGER(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en),
    .inc_btn(zb_inc), .dec_btn(zb_dec),
    .pwm_out(pwm_s), .duty_o(duty_s),
    .period_start(ps_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Current sample is phase 0; MSB holds the earliest sample.
  task automatic cap10();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        w[c][9-j]  = pwm_out[c];
        ws[c][9-j] = pwm_s[c];
      end
      ps[9-j] = period_start;
    end
  endtask

  task automatic sync_period();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (period_start) found = 1'b1;
    end
    chk("sync_period", 32'(found), 32'd1);
  endtask

  task automatic press(input bit up, input int ch);
    if (up) inc_btn[ch] = 1'b1;
    else    dec_btn[ch] = 1'b1;
    repeat (6) @(negedge clk);
    if (up) inc_btn[ch] = 1'b0;
    else    dec_btn[ch] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [9:0] stg [4];
    stg[0] = 10'b1111100000;
    stg[1] = 10'b1110000011;
    stg[2] = 10'b1000001111;
    stg[3] = 10'b0000111110;

    rst_n   = 1'b0;
    en      = 1'b0;
    inc_btn = '0;
    dec_btn = '0;
    zb_inc  = '0;
    zb_dec  = '0;
    repeat (3) @(negedge clk);

    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_ps", 32'(period_start), 32'h0);
    chk("rst_duty", 32'(duty_o), 32'h5555);

    // run with default duty
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk("first_ps", 32'(period_start), 32'h1);
    cap10();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("init_lane%0d", c),
          32'(w[c]), 32'(10'b1111100000));
      chk($sformatf("stagger_lane%0d", c),
          32'(ws[c]), 32'(stg[c]));
    end
    chk("init_ps", 32'(ps), 32'(10'b1000000000));
    chk("init_duty", 32'(duty_o), 32'h5555);

    // long inc hold on channel 0
    sync_period();
    inc_btn[0] = 1'b1;
    cap10();
    chk("inc0_old_lane0", 32'(w[0]),
        32'(10'b1111100000));
    @(negedge clk);
    cap10();
    chk("inc0_new_lane0", 32'(w[0]),
        32'(10'b1111110000));
    for (int c = 1; c < 4; c++)
      chk($sformatf("inc0_lane%0d", c),
          32'(w[c]), 32'(10'b1111100000));
    chk("inc0_ps", 32'(ps), 32'(10'b1000000000));
    chk("inc0_duty", 32'(duty_o), 32'h5556);
    repeat (20) @(negedge clk);
    chk("inc0_hold_duty", 32'(duty_o), 32'h5556);
    inc_btn[0] = 1'b0;
    repeat (6) @(negedge clk);

    // saturate channel 1 high
    for (int k = 0; k < 7; k++) press(1'b1, 1);
    sync_period();
    chk("sat_hi_duty", 32'(duty_o), 32'h55A6);
    cap10();
    chk("sat_hi_lane1", 32'(w[1]), 32'(10'h3FF));
    chk("sat_hi_lane0", 32'(w[0]),
        32'(10'b1111110000));

    // saturate channel 1 low
    for (int k = 0; k < 11; k++) press(1'b0, 1);
    sync_period();
    chk("sat_lo_duty", 32'(duty_o), 32'h5506);
    cap10();
    chk("sat_lo_lane1", 32'(w[1]), 32'h0);

    // simultaneous inc and dec on channel 2
    inc_btn[2] = 1'b1;
    dec_btn[2] = 1'b1;
    repeat (6) @(negedge clk);
    inc_btn[2] = 1'b0;
    dec_btn[2] = 1'b0;
    repeat (6) @(negedge clk);
    sync_period();
    chk("both_duty", 32'(duty_o), 32'h5506);

    // disable mid-period, adjust channel 3
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_pwm", 32'(pwm_out), 32'h0);
    chk("dis_ps", 32'(period_start), 32'h0);
    press(1'b0, 3);
    chk("dis_duty", 32'(duty_o), 32'h4506);
    chk("dis_pwm2", 32'(pwm_out), 32'h0);
    chk("dis_ps2", 32'(period_start), 32'h0);
    en = 1'b1;
    @(negedge clk);
    chk("en_ps", 32'(period_start), 32'h1);
    cap10();
    chk("en_lane0", 32'(w[0]), 32'(10'b1111110000));
    chk("en_lane1", 32'(w[1]), 32'h0);
    chk("en_lane2", 32'(w[2]), 32'(10'b1111100000));
    chk("en_lane3", 32'(w[3]), 32'(10'b1111000000));
    chk("en_ps_pat", 32'(ps), 32'(10'b1000000000));

    // asynchronous reset mid-run
    repeat (3) @(negedge clk);
    chk("pre_rst_pwm", 32'(pwm_out), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'h0);
    chk("arst_ps", 32'(period_start), 32'h0);
    chk("arst_duty", 32'(duty_o), 32'h5555);
    @(negedge clk);
    chk("arst_hold_pwm", 32'(pwm_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ps", 32'(period_start), 32'h1);
    chk("post_rst_pwm", 32'(pwm_out), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
